// File: rtl/alu_mdu.sv
// ---------------------------------------------------------------------------
// alu_mdu
// EX-stage ALU for the MIPS core. Single-cycle logic/shift/add/compare ops
// plus multi-cycle MULT/MULTU and DIV/DIVU writing internal HI/LO registers.
// The result is registered, and the input side uses a valid/ready handshake.
//
// Ports
//   clk        clock, all state on the rising edge
//   resetn     asynchronous active-low reset
//   in_valid   op/a/b/sa valid this cycle
//   in_ready   block can accept (idle); does not depend on any input
//   op         operation code (0..24, 25..31 illegal)
//   a, b       rs, rt operands
//   sa         immediate shift amount
//   flush      abort the in-flight op and drop the same-cycle input
//   out_valid  one-cycle pulse, y/overflow/zero valid
//   y          result
//   overflow   signed overflow of ADD/SUB
//   zero       y == 0
//   hi, lo     current HI/LO register contents
// ---------------------------------------------------------------------------
module alu_mdu #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 3,
    parameter bit DIV_EN  = 1'b1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               op,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [$clog2(WIDTH)-1:0] sa,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         y,
    output logic                     overflow,
    output logic                     zero,
    output logic [WIDTH-1:0]         hi,
    output logic [WIDTH-1:0]         lo
);

    localparam int SHW     = $clog2(WIDTH);
    localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [4:0] OP_AND   = 5'd0;
    localparam logic [4:0] OP_OR    = 5'd1;
    localparam logic [4:0] OP_XOR   = 5'd2;
    localparam logic [4:0] OP_NOR   = 5'd3;
    localparam logic [4:0] OP_LUI   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_SLLV  = 5'd8;
    localparam logic [4:0] OP_SRLV  = 5'd9;
    localparam logic [4:0] OP_SRAV  = 5'd10;
    localparam logic [4:0] OP_ADD   = 5'd11;
    localparam logic [4:0] OP_ADDU  = 5'd12;
    localparam logic [4:0] OP_SUB   = 5'd13;
    localparam logic [4:0] OP_SUBU  = 5'd14;
    localparam logic [4:0] OP_SLT   = 5'd15;
    localparam logic [4:0] OP_SLTU  = 5'd16;
    localparam logic [4:0] OP_MULT  = 5'd17;
    localparam logic [4:0] OP_MULTU = 5'd18;
    localparam logic [4:0] OP_DIV   = 5'd19;
    localparam logic [4:0] OP_DIVU  = 5'd20;
    localparam logic [4:0] OP_MFHI  = 5'd21;
    localparam logic [4:0] OP_MFLO  = 5'd22;
    localparam logic [4:0] OP_MTHI  = 5'd23;
    localparam logic [4:0] OP_MTLO  = 5'd24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   rem;
    logic               mul_signed;
    logic               neg_q;
    logic               neg_r;

    logic               accept;
    logic               is_mul;
    logic               is_div;
    logic               div_start;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   res;
    logic               res_ovf;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   trial;
    logic               sub_ok;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;

    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_valid && in_ready && !flush;
    assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign div_start = accept && is_div && DIV_EN && (b != '0);
    assign zero      = (y == '0);

    assign sum  = a + b;
    assign diff = a - b;

    // The divider works on magnitudes; signs are reapplied in the final cycle.
    assign a_neg = (op == OP_DIV) && a[WIDTH-1];
    assign b_neg = (op == OP_DIV) && b[WIDTH-1];
    assign abs_a = a_neg ? -a : a;
    assign abs_b = b_neg ? -b : b;

    // One restoring step: opa holds the dividend shifting out at the top and
    // the quotient shifting in at the bottom. The partial remainder is always
    // below the divisor, so the low WIDTH bits of the difference are exact.
    assign shifted = {rem, opa[WIDTH-1]};
    assign sub_ok  = (shifted >= {1'b0, opb});
    assign trial   = shifted[WIDTH-1:0] - opb;

    assign ext_a   = mul_signed ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
    assign ext_b   = mul_signed ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
    assign product = ext_a * ext_b;

    // Single-cycle result and overflow for the op presented at the input.
    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_LUI:  res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLL:  res = b << sa;
            OP_SRL:  res = b >> sa;
            OP_SRA:  res = $signed(b) >>> sa;
            OP_SLLV: res = b << a[SHW-1:0];
            OP_SRLV: res = b >> a[SHW-1:0];
            OP_SRAV: res = $signed(b) >>> a[SHW-1:0];
            OP_ADD: begin
                res     = sum;
                res_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: res = sum;
            OP_SUB: begin
                res     = diff;
                res_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBU: res = diff;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MFHI: res = hi;
            OP_MFLO: res = lo;
            default: res = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; flush overrides everything, including a same-cycle accept.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept && is_mul) begin
                    state_nx = ST_MUL;
                end else if (div_start) begin
                    state_nx = ST_DIV;
                end
            end
            ST_MUL:  if (cnt == '0) state_nx = ST_IDLE;
            ST_DIV:  if (cnt == '0) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        if (flush) begin
            state_nx = ST_IDLE;
        end
    end

    // Datapath: result register, HI/LO, and the multiply/divide working state.
    // A flushed cycle leaves every register alone apart from dropping out_valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid  <= 1'b0;
            y          <= '0;
            overflow   <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            cnt        <= '0;
            opa        <= '0;
            opb        <= '0;
            rem        <= '0;
            mul_signed <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (!flush) begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            if (is_mul) begin
                                opa        <= a;
                                opb        <= b;
                                mul_signed <= (op == OP_MULT);
                                cnt        <= CW'(MUL_LAT - 1);
                            end else if (div_start) begin
                                opa   <= abs_a;
                                opb   <= abs_b;
                                rem   <= '0;
                                neg_q <= a_neg ^ b_neg;
                                neg_r <= a_neg;
                                cnt   <= CW'(WIDTH);
                            end else begin
                                out_valid <= 1'b1;
                                y         <= res;
                                overflow  <= res_ovf;
                                if (is_div && DIV_EN) begin
                                    hi <= a;
                                    lo <= '1;
                                end
                                if (op == OP_MTHI) hi <= a;
                                if (op == OP_MTLO) lo <= a;
                            end
                        end
                    end
                    ST_MUL: begin
                        if (cnt == '0) begin
                            {hi, lo}  <= product;
                            y         <= '0;
                            overflow  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    ST_DIV: begin
                        if (cnt == '0) begin
                            lo        <= neg_q ? -opa : opa;
                            hi        <= neg_r ? -rem : rem;
                            y         <= '0;
                            overflow  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            if (sub_ok) begin
                                rem <= trial;
                                opa <= {opa[WIDTH-2:0], 1'b1};
                            end else begin
                                rem <= shifted[WIDTH-1:0];
                                opa <= {opa[WIDTH-2:0], 1'b0};
                            end
                            cnt <= cnt - CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// ---------------------------------------------------------------------------
// tb_alu_mdu
// Directed bench for alu_mdu. Expected results are queued when an op is
// driven and popped when the DUT pulses out_valid. Inputs change and outputs
// are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_alu_mdu;

    localparam int W       = 32;
    localparam int MUL_LAT = 3;

    localparam logic [4:0] AND_OP = 5'd0;
    localparam logic [4:0] OR_OP  = 5'd1;
    localparam logic [4:0] XOR_OP = 5'd2;
    localparam logic [4:0] NOR_OP = 5'd3;
    localparam logic [4:0] LUI_OP = 5'd4;
    localparam logic [4:0] SLL_OP = 5'd5;
    localparam logic [4:0] SRL_OP = 5'd6;
    localparam logic [4:0] SRA_OP = 5'd7;
    localparam logic [4:0] SLLV   = 5'd8;
    localparam logic [4:0] SRLV   = 5'd9;
    localparam logic [4:0] SRAV   = 5'd10;
    localparam logic [4:0] ADD    = 5'd11;
    localparam logic [4:0] ADDU   = 5'd12;
    localparam logic [4:0] SUB    = 5'd13;
    localparam logic [4:0] SUBU   = 5'd14;
    localparam logic [4:0] SLT    = 5'd15;
    localparam logic [4:0] SLTU   = 5'd16;
    localparam logic [4:0] MULT   = 5'd17;
    localparam logic [4:0] MULTU  = 5'd18;
    localparam logic [4:0] DIV    = 5'd19;
    localparam logic [4:0] DIVU   = 5'd20;
    localparam logic [4:0] MFHI   = 5'd21;
    localparam logic [4:0] MFLO   = 5'd22;
    localparam logic [4:0] MTHI   = 5'd23;
    localparam logic [4:0] MTLO   = 5'd24;

    logic         clk;
    logic         resetn;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   sa;
    logic         flush;
    logic         out_valid;
    logic [W-1:0] y;
    logic         overflow;
    logic         zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        string        tag;
        logic [W-1:0] y;
        logic         ovf;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t sb_q[$];

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;

    logic [W-1:0] mhi;
    logic [W-1:0] mlo;

    alu_mdu #(
        .WIDTH   (W),
        .MUL_LAT (MUL_LAT),
        .DIV_EN  (1'b1)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .sa        (sa),
        .flush     (flush),
        .out_valid (out_valid),
        .y         (y),
        .overflow  (overflow),
        .zero      (zero),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends even if the DUT stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one op for a single accept edge and queues its expected result.
    task automatic applyStimulus(input string tag, input logic [4:0] iop,
                                 input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic [4:0] isa, input logic [W-1:0] ey,
                                 input logic eovf, input logic [W-1:0] ehi,
                                 input logic [W-1:0] elo);
        exp_t e;
        e.tag = tag;
        e.y   = ey;
        e.ovf = eovf;
        e.hi  = ehi;
        e.lo  = elo;
        sb_q.push_back(e);
        op       = iop;
        a        = ia;
        b        = ib;
        sa       = isa;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Pops the oldest expectation and compares it with the current outputs.
    task automatic checkOutput();
        exp_t e;
        check("scoreboard_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({e.tag, ".out_valid"}, 32'(out_valid), 32'd1);
            check({e.tag, ".in_ready"}, 32'(in_ready), 32'd1);
            check({e.tag, ".y"}, y, e.y);
            check({e.tag, ".overflow"}, 32'(overflow), 32'(e.ovf));
            check({e.tag, ".zero"}, 32'(zero), 32'(e.y == 32'd0));
            check({e.tag, ".hi"}, hi, e.hi);
            check({e.tag, ".lo"}, lo, e.lo);
        end
    endtask

    // Waits (bounded) for out_valid, counting busy cycles along the way.
    task automatic waitOutput(input string tag, input int budget, input int exp_busy);
        int busy = 0;
        int cyc  = 0;
        while (!out_valid && cyc < budget) begin
            if (!in_ready) busy++;
            @(negedge clk);
            cyc++;
        end
        check({tag, ".busy_cycles"}, 32'(busy), 32'(exp_busy));
        checkOutput();
    endtask

    task automatic singleOp(input string tag, input logic [4:0] iop,
                            input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic [4:0] isa, input logic [W-1:0] ey,
                            input logic eovf);
        applyStimulus(tag, iop, ia, ib, isa, ey, eovf, mhi, mlo);
        waitOutput(tag, 2, 0);
    endtask

    initial begin
        logic seen;
        logic [W-1:0] y_before;

        resetn   = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        op       = '0;
        a        = '0;
        b        = '0;
        sa       = '0;
        mhi      = '0;
        mlo      = '0;

        repeat (2) @(negedge clk);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.y", y, 32'd0);
        check("reset.zero", 32'(zero), 32'd1);
        check("reset.overflow", 32'(overflow), 32'd0);
        check("reset.hi", hi, 32'd0);
        check("reset.lo", lo, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("post_reset.out_valid", 32'(out_valid), 32'd0);

        $display("[TB] single-cycle ops");
        singleOp("add_ovf",  ADD,  32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b1);
        singleOp("addu",     ADDU, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b0);
        singleOp("sub_ovf",  SUB,  32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b1);
        singleOp("subu",     SUBU, 32'h5, 32'h7, 5'd0, 32'hFFFFFFFE, 1'b0);
        singleOp("srav",     SRAV, 32'h00000024, 32'h80000000, 5'd0, 32'hF8000000, 1'b0);
        singleOp("srlv",     SRLV, 32'h00000024, 32'h80000000, 5'd0, 32'h08000000, 1'b0);
        singleOp("sllv",     SLLV, 32'h00000021, 32'h3, 5'd0, 32'h6, 1'b0);
        singleOp("sll",      SLL_OP, 32'h0, 32'h1, 5'd31, 32'h80000000, 1'b0);
        singleOp("sra",      SRA_OP, 32'h0, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0);
        singleOp("srl",      SRL_OP, 32'h0, 32'h80000000, 5'd31, 32'h1, 1'b0);
        singleOp("slt",      SLT,  32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 1'b0);
        singleOp("sltu",     SLTU, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b0);
        singleOp("lui",      LUI_OP, 32'h0, 32'h1234ABCD, 5'd0, 32'hABCD0000, 1'b0);
        singleOp("and",      AND_OP, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0);
        singleOp("or",       OR_OP,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0, 1'b0);
        singleOp("xor",      XOR_OP, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FF00FF0, 1'b0);
        singleOp("nor",      NOR_OP, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0);
        singleOp("illegal",  5'd25, 32'h1, 32'h1, 5'd0, 32'h0, 1'b0);

        $display("[TB] HI/LO moves back-to-back");
        mhi = 32'h00001234;
        singleOp("mthi", MTHI, 32'h00001234, 32'h0, 5'd0, 32'h0, 1'b0);
        singleOp("mfhi", MFHI, 32'h0, 32'h0, 5'd0, 32'h00001234, 1'b0);
        mlo = 32'h00005678;
        singleOp("mtlo", MTLO, 32'h00005678, 32'h0, 5'd0, 32'h0, 1'b0);
        singleOp("mflo", MFLO, 32'h0, 32'h0, 5'd0, 32'h00005678, 1'b0);

        $display("[TB] multiply");
        mhi = 32'hFFFFFFFF;
        mlo = 32'hFFFFFFFA;
        applyStimulus("mult", MULT, 32'hFFFFFFFE, 32'h3, 5'd0, 32'h0, 1'b0, mhi, mlo);
        waitOutput("mult", 20, MUL_LAT);
        @(negedge clk);
        check("mult.pulse_once", 32'(out_valid), 32'd0);
        mhi = 32'hFFFFFFFE;
        mlo = 32'h00000001;
        applyStimulus("multu", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b0, mhi, mlo);
        waitOutput("multu", 20, MUL_LAT);
        singleOp("mflo_after_mul", MFLO, 32'h0, 32'h0, 5'd0, 32'h00000001, 1'b0);

        $display("[TB] divide");
        mhi = 32'hFFFFFFFF;
        mlo = 32'hFFFFFFFD;
        applyStimulus("div_neg", DIV, 32'hFFFFFFF9, 32'h2, 5'd0, 32'h0, 1'b0, mhi, mlo);
        waitOutput("div_neg", 60, W + 1);
        @(negedge clk);
        check("div.pulse_once", 32'(out_valid), 32'd0);
        mhi = 32'h00000001;
        mlo = 32'hFFFFFFFD;
        applyStimulus("div_negb", DIV, 32'h00000007, 32'hFFFFFFFE, 5'd0, 32'h0, 1'b0, mhi, mlo);
        waitOutput("div_negb", 60, W + 1);
        mhi = 32'h00000000;
        mlo = 32'h80000000;
        applyStimulus("div_min", DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b0, mhi, mlo);
        waitOutput("div_min", 60, W + 1);
        mhi = 32'h00000002;
        mlo = 32'h0000000E;
        applyStimulus("divu", DIVU, 32'd100, 32'd7, 5'd0, 32'h0, 1'b0, mhi, mlo);
        waitOutput("divu", 60, W + 1);
        mhi = 32'h12345678;
        mlo = 32'hFFFFFFFF;
        applyStimulus("divu_by0", DIVU, 32'h12345678, 32'h0, 5'd0, 32'h0, 1'b0, mhi, mlo);
        waitOutput("divu_by0", 2, 0);

        $display("[TB] flush");
        y_before = y;
        op       = ADD;
        a        = 32'h1;
        b        = 32'h1;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle.out_valid", 32'(out_valid), 32'd0);
        check("flush_idle.y", y, y_before);

        op       = DIVU;
        a        = 32'd1000;
        b        = 32'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("flush_div.busy", 32'(in_ready), 32'd0);
        op       = ADD;
        a        = 32'h1;
        b        = 32'h1;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_div.in_ready", 32'(in_ready), 32'd1);
        check("flush_div.out_valid", 32'(out_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_div.no_result", 32'(seen), 32'd0);
        check("flush_div.hi", hi, mhi);
        check("flush_div.lo", lo, mlo);
        check("flush_div.y", y, y_before);
        singleOp("add_after_flush", ADD, 32'h2, 32'h3, 5'd0, 32'h5, 1'b0);

        $display("[TB] reset during divide");
        singleOp("add_pre_reset", ADD, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b1);
        op       = DIV;
        a        = 32'd100;
        b        = 32'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_div.busy", 32'(in_ready), 32'd0);
        resetn = 1'b0;
        #1;
        check("rst_div.out_valid", 32'(out_valid), 32'd0);
        check("rst_div.in_ready", 32'(in_ready), 32'd1);
        check("rst_div.y", y, 32'd0);
        check("rst_div.zero", 32'(zero), 32'd1);
        check("rst_div.overflow", 32'(overflow), 32'd0);
        check("rst_div.hi", hi, 32'd0);
        check("rst_div.lo", lo, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("rst_div.no_result", 32'(seen), 32'd0);
        check("rst_div.hi_hold", hi, 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
